// File: rtl/w232c_tx.sv
// w232c_tx: word-level RS-232C transmitter. A 2-entry word FIFO feeds a serializer that sends four frames per word, MSB byte first.
// Define W232C_PARITY_EN to add an even-parity bit after the data bits (8E1 instead of 8N1).
module w232c_tx #(
    parameter logic [15:0] wtime = 16'h0006
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy
);

`ifdef W232C_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] active_q, active_d;
    logic [7:0]  shift_q, shift_d;
    logic [31:0] mem_q [2];
    logic [31:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        in_ready_q, in_ready_d;
`ifdef W232C_PARITY_EN
    logic        parity_q, parity_d;
`endif
    logic        push, pop, bit_done;
    logic [31:0] head;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_of = w[31:24];
            2'd1:    byte_of = w[23:16];
            2'd2:    byte_of = w[15:8];
            default: byte_of = w[7:0];
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        active_d = active_q;
        shift_d  = shift_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tx_d     = 1'b1;
        pop      = 1'b0;
        push     = in_valid && in_ready_q;
        head     = mem_q[rd_ptr_q];
        bit_done = (timer_q == 16'd0);
`ifdef W232C_PARITY_EN
        parity_d = parity_q;
`endif
        if (!bit_done) timer_d = timer_q - 16'd1;

        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    pop      = 1'b1;
                    active_d = head;
                    idx_d    = 2'd0;
                    shift_d  = head[31:24];
                    timer_d  = wtime - 16'd1;
                    state_d  = START;
                end
            end
            START: begin
                tx_d = 1'b0;
`ifdef W232C_PARITY_EN
                parity_d = 1'b0;
`endif
                if (bit_done) begin
                    timer_d = wtime - 16'd1;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    timer_d = wtime - 16'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef W232C_PARITY_EN
                    parity_d = parity_q ^ shift_q[0];
                    if (bit_q == 3'd7) state_d = PARITY;
`else
                    if (bit_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef W232C_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (bit_done) begin
                    timer_d = wtime - 16'd1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    timer_d = wtime - 16'd1;
                    // Next byte of this word, else next word straight from the FIFO, with no idle gap.
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        shift_d = byte_of(active_q, idx_q + 2'd1);
                        state_d = START;
                    end else if (count_q != 2'd0) begin
                        pop      = 1'b1;
                        active_d = head;
                        idx_d    = 2'd0;
                        shift_d  = head[31:24];
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        in_ready_d = (count_d != 2'd2);
        busy_d     = (state_q != IDLE) || (count_q != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= 16'd0;
            bit_q      <= 3'd0;
            idx_q      <= 2'd0;
            active_q   <= 32'd0;
            shift_q    <= 8'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
`ifdef W232C_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
`ifdef W232C_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // FIFO storage needs no reset: occupancy and pointers gate every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready = in_ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_w232c_tx.sv
// Testbench for w232c_tx: scoreboard of expected bytes checked against a mid-bit sampling serial receiver model.
module tb_w232c_tx;
    localparam logic [15:0] WTIME = 16'd6;
    localparam int W = 6;
`ifdef W232C_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * W;
    localparam int WORD_CYC  = 4 * FRAME_CYC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, tx, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    w232c_tx #(.wtime(WTIME)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Offers a word from a negedge, returns one negedge after the accepting edge with in_valid still high.
    task automatic send(input logic [31:0] w, output int acc);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        acc = cyc;
        @(negedge clk);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic rx_frame(output logic [7:0] b, output logic par, output logic fr,
                            output int st, output logic to);
        int n = 0;
        logic sb;
        b = 8'd0; par = 1'b0; fr = 1'b0; to = 1'b0;
        do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < 3000);
        st = cyc;
        if (tx !== 1'b0) begin
            to = 1'b1;
        end else begin
            repeat (W / 2) @(negedge clk);
            sb = tx;
            for (int i = 0; i < 8; i++) begin repeat (W) @(negedge clk); b[i] = tx; end
`ifdef W232C_PARITY_EN
            repeat (W) @(negedge clk);
            par = tx;
`endif
            repeat (W) @(negedge clk);
            fr = (sb === 1'b0) && (tx === 1'b1);
        end
    endtask

    // Scoreboard consumer: each received frame is popped and compared, and frames must be contiguous.
    task automatic rx_scoreboard(input int nbytes, input string tag, output int first_st);
        logic [7:0] b, e;
        logic par, fr, to;
        int st, prev;
        first_st = 0;
        prev = 0;
        for (int i = 0; i < nbytes; i++) begin
            rx_frame(b, par, fr, st, to);
            if (i == 0) first_st = st;
            checks++;
            if (to) begin
                errors++;
                $display("FAIL %s_rx%0d: no start bit within bound, required a frame", tag, i);
                break;
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_rx%0d: got byte %h, required none (scoreboard empty)", tag, i, b);
            end else begin
                e = exp_q.pop_front();
                if (b !== e || fr !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %h framing_ok=%b, required %h framing_ok=1", tag, i, b, fr, e);
                end
`ifdef W232C_PARITY_EN
                checks++;
                if (par !== ^e) begin
                    errors++;
                    $display("FAIL %s_parity%0d: got %b, required %b", tag, i, par, ^e);
                end
`endif
            end
            if (i > 0) begin
                checks++;
                if (st - prev != FRAME_CYC) begin
                    errors++;
                    $display("FAIL %s_gap%0d: start spacing %0d, required %0d", tag, i, st - prev, FRAME_CYC);
                end
            end
            prev = st;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_word;
        int acc, st;
        repeat (20) @(negedge clk);
        send(32'hDEADBEEF, acc);
        in_valid = 1'b0;
        rx_scoreboard(4, "single", st);
        checks++;
        if (st - acc != 3) begin errors++; $display("FAIL single_latency: got %0d, required 3", st - acc); end
        while (cyc < st + WORD_CYC - 1) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b, required 1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_end: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_bit_timing;
        int acc, st, n;
        logic [7:0] e;
        logic [FRAME_BITS-1:0] fb;
        logic [FRAME_CYC-1:0] obs;
        logic [W-1:0] win;
        repeat (20) @(negedge clk);
        send(32'h55000000, acc);
        in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < 3000);
        st = cyc;
        checks++;
        if (st - acc != 3) begin errors++; $display("FAIL timing_latency: got %0d, required 3", st - acc); end
        e = exp_q.pop_front();
`ifdef W232C_PARITY_EN
        fb = {1'b1, ^e, e, 1'b0};
`else
        fb = {1'b1, e, 1'b0};
`endif
        obs[0] = tx;
        for (int k = 1; k < FRAME_CYC; k++) begin @(negedge clk); obs[k] = tx; end
        for (int b = 0; b < FRAME_BITS; b++) begin
            win = obs[b*W +: W];
            checks++;
            if (win !== {W{fb[b]}}) begin
                errors++;
                $display("FAIL timing_bit%0d: got %b, required %b", b, win, {W{fb[b]}});
            end
        end
        rx_scoreboard(3, "timing", st);
    endtask

    task automatic test_back_to_back;
        int a1, a2, a3, a4, st;
        repeat (20) @(negedge clk);
        fork
            begin
                send(32'h00000001, a1);
                send(32'h00000002, a2);
                send(32'h00000003, a3);
                send(32'h00000004, a4);
                in_valid = 1'b0;
            end
            rx_scoreboard(16, "b2b", st);
        join
        checks += 4;
        if (a2 - a1 != 1) begin errors++; $display("FAIL b2b_acc2: got +%0d, required +1", a2 - a1); end
        if (a3 - a1 != 2) begin errors++; $display("FAIL b2b_acc3: got +%0d, required +2", a3 - a1); end
        if (a4 - a1 != WORD_CYC + 2) begin
            errors++;
            $display("FAIL b2b_acc4: got +%0d, required +%0d", a4 - a1, WORD_CYC + 2);
        end
        if (st - a1 != 3) begin errors++; $display("FAIL b2b_latency: got %0d, required 3", st - a1); end
    endtask

    task automatic test_end_marker;
        int a1, a2, st;
        repeat (20) @(negedge clk);
        send(32'hFFFFFFFF, a1);
        send(32'h0000000A, a2);
        in_valid = 1'b0;
        rx_scoreboard(8, "marker", st);
        checks++;
        if (st - a1 != 3) begin errors++; $display("FAIL marker_latency: got %0d, required 3", st - a1); end
    endtask

    task automatic test_reset_mid;
        int acc, st, lows;
        repeat (20) @(negedge clk);
        send(32'hA5A5A5A5, acc);
        send(32'h3C3C3C3C, acc);
        in_valid = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b, required 1", tx); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        rst = 1'b0;
        exp_q.delete();
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL rstmid_idle: %0d active cycles, required 0", lows); end
        send(32'h12345678, acc);
        in_valid = 1'b0;
        rx_scoreboard(4, "rstmid", st);
        checks++;
        if (st - acc != 3) begin errors++; $display("FAIL rstmid_latency: got %0d, required 3", st - acc); end
    endtask

`ifdef W232C_PARITY_EN
    task automatic test_parity;
        int acc, st;
        repeat (20) @(negedge clk);
        send(32'h07000000, acc);
        in_valid = 1'b0;
        rx_scoreboard(4, "parity", st);
        while (cyc < st + 44 * W - 1) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL parity_busy_last: got %b, required 1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL parity_word_len: busy=%b, required 0", busy); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_bit_timing();
        test_back_to_back();
        test_end_marker();
        test_reset_mid();
`ifdef W232C_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/w232c_tx.md
# w232c_tx

Word-level RS-232C transmitter. Accepts 32-bit words over a valid/ready handshake, buffers them in a 2-entry word FIFO, and serializes each word as four 8N1 byte frames, most-significant byte first, LSB-first within each byte. It is the transmit-side counterpart of `i232c`. It sits between the core's output port logic and the `RS_TX` pin, and its output is decodable by `i232c` using the same `wtime`.

## Interface

- `wtime`, default `16'h0006`: clocks per serial bit; legal range 2..65535.
- `clk` input, 1 bit: system clock; all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_data` input, 32 bits: word to transmit.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: FIFO can accept a word. A transfer occurs on a cycle where `in_valid` and `in_ready` are both high.
- `tx` output, 1 bit: serial line; idle high.
- `busy` output, 1 bit: high while a frame is on the line or the FIFO is non-empty.

## Operation

- **Storage**
  - 2-entry word FIFO.
  - One active word register.
  - Byte index, 0..3.
- **Serializer FSM states:** IDLE, START, DATA, STOP, plus PARITY when configured.
- **IDLE**
  - `tx`=1.
  - If the FIFO is non-empty: pop the head into the active register, set byte index 0, and go to START.
- **START**
  - `tx`=0 for `wtime` clocks.
  - Load `shift` with byte `active[31-8*idx -: 8]`.
- **DATA**
  - `tx`=`shift[0]`.
  - After each `wtime` clocks: shift right and increment the bit counter (0..7).
  - After bit 7, go to STOP (or PARITY).
- **STOP**
  - `tx`=1 for `wtime` clocks. Then:
    - If idx<3: idx++ and go to START. There is no idle gap between the bytes of a word.
    - Else, if the FIFO is non-empty: pop and go to START immediately. Words are sent back-to-back.
    - Else: go to IDLE.
- **Bit timer**
  - 16-bit down-counter, loaded with `wtime-1` on entry to each bit.
  - The bit ends on the cycle the timer reads 0.
- **FIFO**
  - `in_ready` = FIFO not full. It is combinational on FIFO occupancy only and does not depend on `in_valid`.
  - Simultaneous push and pop when full: the pop frees a slot only on the next cycle, so `in_ready` stays 0 that cycle.
  - Simultaneous push and pop when the FIFO holds exactly 1 word: occupancy is unchanged and order is preserved.
  - Push when empty while the FSM is in IDLE: the word appears at the FIFO head next cycle. START begins the cycle after that.
- **Reset** (may assert at any time, including mid-frame)
  - FIFO is emptied; the active word is discarded.
  - FSM goes to IDLE.
  - Reset values: `tx`=1, `in_ready`=1, `busy`=0.
  - A partially sent frame is truncated. The line returns high, and the receiver sees at worst a framing error.
- **`busy`:** high in every non-IDLE state or while FIFO occupancy is >0.

## Timing

- `tx` is driven from a flop.
- Latency from an accepted `in_valid` (FSM idle, FIFO empty) to the falling start edge on `tx`: 3 clocks.
- Byte frame: 10×`wtime` clocks; 11×`wtime` with parity.
- Word: 40×`wtime` clocks; 44×`wtime` with parity.
- Every bit is exactly `wtime` clocks, with no jitter.
- Consecutive frames are contiguous: the next start bit begins on the clock after the last stop-bit clock.
- Throughput: capacity is 3 words (2 FIFO entries plus the active word). The host may stream continuously while `in_ready`=1.

## Configuration

- **`W232C_PARITY_EN`**
  - **Defined:** a PARITY state is inserted between DATA and STOP. `tx` = even parity (XOR of the 8 data bits) for `wtime` clocks; frame length is 11 bits.
  - **Undefined:** the PARITY state and its logic are absent; frames are 8N1.
  - The default build leaves it undefined, for compatibility with `i232c`.

## Test plan

All scenarios use `wtime`=6.

- **Reset mid-operation:** hold `rst`=1 for 2 clocks mid-frame → `tx`=1, `in_ready`=1, `busy`=0 on the next clock. FIFO is empty; a following word is sent cleanly.
- **Single word:** push `32'hDEADBEEF` → `i232c` receives DE, AD, BE, EF in order.
  - Start edge 3 clocks after acceptance.
  - 240 clocks from the start edge to the end of the last stop bit.
  - Then `busy` falls.
- **Bit timing:** push `32'h55000000` → 0/1 alternation on `tx` with every bit exactly 6 clocks; the stop bit is high for 6 clocks.
- **Back-pressure:** push 4 words `32'h00000001`..`32'h00000004` with `in_valid` held high.
  - The first 3 are accepted.
  - `in_ready`=0 until word 1 completes and word 2 is popped; word 4 is accepted 1 clock later.
  - All 16 bytes arrive in order with no idle gap.
- **End marker plus value:** push `32'hFFFFFFFF` then `32'h0000000A` → bytes FF FF FF FF 00 00 00 0A, contiguous.
- **Parity (`W232C_PARITY_EN` defined):** push `32'h07000000` → first frame has 11 bits and its parity bit = 1; byte 0x00 frames have parity 0; word length 264 clocks.
